// File: rtl/logic_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_pipe
// Description : Reduces CHANNELS masked input words into one WIDTH-bit word
//               with a run-time selected bitwise operation (OR/AND/XOR and
//               their inversions), then carries the result through a
//               PIPE_STAGES-deep valid/ready pipeline with a single global
//               advance. Bubbles are not collapsed.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_pipe #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [CHANNELS*WIDTH-1:0] IN_BUS,
    input  logic [CHANNELS-1:0]       IN_MASK,
    input  logic [2:0]                IN_OP,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [WIDTH-1:0]          OUT0,
    output logic [2:0]                OUT_OP,
    output logic                      OUT_ALL_MASKED,
    output logic                      OUT_ERR
);

    // Opcode encoding
    localparam logic [2:0] C_OP_OR   = 3'd0;
    localparam logic [2:0] C_OP_AND  = 3'd1;
    localparam logic [2:0] C_OP_XOR  = 3'd2;
    localparam logic [2:0] C_OP_NOR  = 3'd3;
    localparam logic [2:0] C_OP_NAND = 3'd4;
    localparam logic [2:0] C_OP_XNOR = 3'd5;

    // Base (non-inverted) reduction kinds
    localparam logic [1:0] C_BASE_OR  = 2'd0;
    localparam logic [1:0] C_BASE_AND = 2'd1;
    localparam logic [1:0] C_BASE_XOR = 2'd2;

    logic [1:0]       w_base;
    logic             w_inv;
    logic             w_err;
    logic             w_all_masked;
    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_result;
    logic             w_adv;

    // Pipeline storage; index 0 is the stage fed by the reduction logic
    logic             r_vld [PIPE_STAGES];
    logic [WIDTH-1:0] r_dat [PIPE_STAGES];
    logic [2:0]       r_op  [PIPE_STAGES];
    logic             r_am  [PIPE_STAGES];
    logic             r_err [PIPE_STAGES];

    // Every stage moves together: advance whenever the output slot is empty
    // or being drained this cycle.
    assign w_adv    = !r_vld[PIPE_STAGES-1] || OUT_READY;
    assign IN_READY = w_adv;

    // Opcode decode into base operation, output inversion and error flag
    always_comb begin
        w_base = C_BASE_OR;
        w_inv  = 1'b0;
        w_err  = 1'b0;
        case (IN_OP)
            C_OP_OR:   w_base = C_BASE_OR;
            C_OP_AND:  w_base = C_BASE_AND;
            C_OP_XOR:  w_base = C_BASE_XOR;
            C_OP_NOR:  begin w_base = C_BASE_OR;  w_inv = 1'b1; end
            C_OP_NAND: begin w_base = C_BASE_AND; w_inv = 1'b1; end
            C_OP_XNOR: begin w_base = C_BASE_XOR; w_inv = 1'b1; end
            default:   w_err  = 1'b1;
        endcase
    end

    // Masked reduction: accumulator starts at the base identity so masked
    // channels simply do not touch it; reserved opcodes force zero.
    always_comb begin
        w_acc = (w_base == C_BASE_AND) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            if (IN_MASK[k]) begin
                case (w_base)
                    C_BASE_AND: w_acc = w_acc & IN_BUS[k*WIDTH +: WIDTH];
                    C_BASE_XOR: w_acc = w_acc ^ IN_BUS[k*WIDTH +: WIDTH];
                    default:    w_acc = w_acc | IN_BUS[k*WIDTH +: WIDTH];
                endcase
            end
        end
        if (w_err) begin
            w_result = {WIDTH{1'b0}};
        end else if (w_inv) begin
            w_result = ~w_acc;
        end else begin
            w_result = w_acc;
        end
        w_all_masked = (IN_MASK == {CHANNELS{1'b0}});
    end

    // Shift register of beats; stage 0 captures the reduction, later stages
    // are plain delays. Data of bubble stages is don't-care.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_vld[s] <= 1'b0;
                r_dat[s] <= {WIDTH{1'b0}};
                r_op[s]  <= 3'd0;
                r_am[s]  <= 1'b0;
                r_err[s] <= 1'b0;
            end
        end else if (w_adv) begin
            r_vld[0] <= IN_VALID;
            r_dat[0] <= w_result;
            r_op[0]  <= IN_OP;
            r_am[0]  <= w_all_masked;
            r_err[0] <= w_err;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_dat[s] <= r_dat[s-1];
                r_op[s]  <= r_op[s-1];
                r_am[s]  <= r_am[s-1];
                r_err[s] <= r_err[s-1];
            end
        end
    end

    assign OUT_VALID      = r_vld[PIPE_STAGES-1];
    assign OUT0           = r_dat[PIPE_STAGES-1];
    assign OUT_OP         = r_op[PIPE_STAGES-1];
    assign OUT_ALL_MASKED = r_am[PIPE_STAGES-1];
    assign OUT_ERR        = r_err[PIPE_STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_gate_pipe
// Description : Self-checking bench for logic_gate_pipe: vector table,
//               hand-written flow-control/reset sequences and a randomized
//               run against a bit-counting reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_gate_pipe;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int PS = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [CH*W-1:0] in_bus;
    logic [CH-1:0]   in_mask;
    logic [2:0]      in_op;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out0;
    logic [2:0]      out_op;
    logic            out_am;
    logic            out_err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [CH*W-1:0] bus;
        logic [CH-1:0]   mask;
        logic [2:0]      op;
        logic [W-1:0]    exp_out;
        logic            exp_am;
        logic            exp_err;
    } vec_t;

    typedef struct {
        logic [W-1:0] o;
        logic [2:0]   op;
        logic         am;
        logic         err;
    } exp_t;

    vec_t vecs [12];
    exp_t q [$];

    logic_gate_pipe #(.WIDTH(W), .CHANNELS(CH), .PIPE_STAGES(PS)) dut (
        .CLK            (clk),
        .RST            (rst),
        .IN_VALID       (in_valid),
        .IN_READY       (in_ready),
        .IN_BUS         (in_bus),
        .IN_MASK        (in_mask),
        .IN_OP          (in_op),
        .OUT_VALID      (out_valid),
        .OUT_READY      (out_ready),
        .OUT0           (out0),
        .OUT_OP         (out_op),
        .OUT_ALL_MASKED (out_am),
        .OUT_ERR        (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: per bit, count how many participating channels are 1.
    // OR = any, AND = all participants, XOR = odd count; ops 3..5 invert.
    function automatic exp_t model(input logic [CH*W-1:0] bus, input logic [CH-1:0] m,
                                   input logic [2:0] op);
        exp_t e;
        e.op  = op;
        e.am  = (m == '0);
        e.err = (op > 3'd5);
        e.o   = '0;
        if (!e.err) begin
            for (int b = 0; b < W; b++) begin
                int cnt = 0;
                int n   = 0;
                logic bitv;
                for (int k = 0; k < CH; k++) begin
                    if (m[k]) begin
                        n++;
                        if (bus[k*W+b]) cnt++;
                    end
                end
                case (op % 3)
                    0:       bitv = (cnt > 0);
                    1:       bitv = (cnt == n);
                    default: bitv = cnt[0];
                endcase
                e.o[b] = (op >= 3'd3) ? !bitv : bitv;
            end
        end
        return e;
    endfunction

    // Send one beat into an idle pipe with OUT_READY=1 and check it appears
    // at nominal latency. Called #1 after a rising edge.
    task automatic send_check(input vec_t v, input string tag);
        in_valid = 1'b1;
        in_bus   = v.bus;
        in_mask  = v.mask;
        in_op    = v.op;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (PS-1) begin @(posedge clk); #1; end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_out0"}, out0, v.exp_out);
        chk({tag, "_op"}, out_op, v.op);
        chk({tag, "_all_masked"}, out_am, v.exp_am);
        chk({tag, "_err"}, out_err, v.exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h80040201, 4'hF, 3'd0, 8'h87, 1'b0, 1'b0};
        vecs[1]  = '{32'hF00FFF00, 4'hF, 3'd5, 8'hFF, 1'b0, 1'b0};
        vecs[2]  = '{32'h0FFF3CF0, 4'h6, 3'd1, 8'h3C, 1'b0, 1'b0};
        vecs[3]  = '{32'h0FFF3CF0, 4'h6, 3'd3, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{32'h0FFF3CF0, 4'h0, 3'd4, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{32'h0FFF3CF0, 4'hF, 3'd7, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{32'h0FFF3CF0, 4'hF, 3'd0, 8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{32'h0FFF3CF0, 4'hF, 3'd2, 8'h3C, 1'b0, 1'b0};
        vecs[8]  = '{32'h0FFF3CF0, 4'h0, 3'd1, 8'hFF, 1'b1, 1'b0};
        vecs[9]  = '{32'h0FFF3CF0, 4'h0, 3'd3, 8'hFF, 1'b1, 1'b0};
        vecs[10] = '{32'h12345678, 4'h0, 3'd6, 8'h00, 1'b1, 1'b1};
        vecs[11] = '{32'h0FFF3CF0, 4'h9, 3'd4, 8'hFF, 1'b0, 1'b0};

        // ---------------- reset with IN_VALID high ----------------
        rst = 1'b1; in_valid = 1'b1; in_bus = 32'hFFFFFFFF; in_mask = 4'hF;
        in_op = 3'd7; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_out0", out0, 0);
        chk("rst_err", out_err, 0);
        chk("rst_op", out_op, 0);
        chk("rst_am", out_am, 0);
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_no_emit", out_valid, 0);
        end

        // ---------------- vector table ----------------
        for (int i = 0; i < 12; i++) begin
            send_check(vecs[i], $sformatf("vec%0d", i));
        end
        @(posedge clk); #1;

        // ---------------- backpressure ----------------
        fork
            begin : bp_drv
                bit acc;
                for (int i = 1; i <= 6; i++) begin
                    in_valid = 1'b1;
                    in_bus   = (CH*W)'(i);
                    in_mask  = 4'hF;
                    in_op    = 3'd0;
                    acc = 1'b0;
                    for (int t = 0; t < 50 && !acc; t++) begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk); #1;
                    end
                    if (!acc) chk("bp_accept_timeout", acc, 1);
                end
                in_valid = 1'b0;
            end
            begin : bp_rdy
                bit seen;
                seen = 1'b0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(posedge clk); #1;
                    if (out_valid) seen = 1'b1;
                end
                chk("bp_first_valid", seen, 1);
                if (seen) begin
                    out_ready = 1'b0;
                    for (int c = 0; c < 3; c++) begin
                        @(negedge clk);
                        chk("bp_hold_valid", out_valid, 1);
                        chk("bp_hold_out0", out0, 8'h01);
                        chk("bp_in_ready_low", in_ready, 0);
                        @(posedge clk); #1;
                    end
                    out_ready = 1'b1;
                end
            end
            begin : bp_col
                int got [$];
                int when [$];
                for (int t = 0; t < 60 && got.size() < 6; t++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        got.push_back(int'(out0));
                        when.push_back(t);
                    end
                end
                chk("bp_count", got.size(), 6);
                for (int i = 0; i < got.size(); i++) begin
                    chk($sformatf("bp_seq%0d", i), got[i], i+1);
                    if (i > 0) chk($sformatf("bp_gap%0d", i), when[i] - when[i-1], 1);
                end
            end
        join
        @(posedge clk); #1;

        // ---------------- reset mid-flight ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; in_bus = 32'h000000AA; in_mask = 4'hF; in_op = 3'd0;
        @(posedge clk); #1;
        in_bus = 32'h00000055;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_out0", out0, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mid_rst_no_emit", out_valid, 0);
        end
        @(posedge clk); #1;
        send_check('{32'h00C30000, 4'h4, 3'd0, 8'hC3, 1'b0, 1'b0}, "post_rst");
        @(posedge clk); #1;

        // ---------------- randomized run ----------------
        begin : rnd
            bit           hold;
            logic [W-1:0] p_out;
            logic [2:0]   p_op;
            logic         p_am, p_err;
            exp_t         e;
            hold = 1'b0;
            p_out = '0; p_op = '0; p_am = 1'b0; p_err = 1'b0;
            for (int cyc = 0; cyc < 420; cyc++) begin
                if (cyc > 0) begin @(posedge clk); #1; end
                if (cyc < 400) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    for (int k = 0; k < CH; k++) in_bus[k*W +: W] = W'($urandom);
                    in_mask  = ($urandom_range(0, 7) == 0) ? '0 : CH'($urandom);
                    in_op    = 3'($urandom_range(0, 7));
                    out_ready = ($urandom_range(0, 2) != 0);
                end else begin
                    in_valid  = 1'b0;
                    out_ready = 1'b1;
                end
                @(negedge clk);
                if (hold) begin
                    chk("rnd_stall_valid", out_valid, 1);
                    chk("rnd_stall_out0", out0, p_out);
                    chk("rnd_stall_op", out_op, p_op);
                    chk("rnd_stall_flags", {out_am, out_err}, {p_am, p_err});
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("rnd_spurious", out_valid, 0);
                    end else begin
                        e = q.pop_front();
                        chk("rnd_out0", out0, e.o);
                        chk("rnd_op", out_op, e.op);
                        chk("rnd_am", out_am, e.am);
                        chk("rnd_err", out_err, e.err);
                    end
                end
                if (in_valid && in_ready) q.push_back(model(in_bus, in_mask, in_op));
                hold  = out_valid && !out_ready;
                p_out = out0; p_op = out_op; p_am = out_am; p_err = out_err;
            end
            chk("rnd_drained", q.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
